// File: rtl/demux_router.sv
// One-to-N demultiplexing router: each channel holds a single registered word,
// with unicast or broadcast delivery and a count of accepted input transfers.
module demux_router #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic                          in_bcast,
    output logic [(2**SEL_W)-1:0]         out_valid,
    output logic [(2**SEL_W)*DATA_W-1:0]  out_data,
    input  logic [(2**SEL_W)-1:0]         out_ready,
    output logic [CNT_W-1:0]              acc_cnt
);

    localparam int N = 2**SEL_W;

    logic [N-1:0]      full;
    logic [DATA_W-1:0] data [N];
    logic [N-1:0]      free;
    logic [N-1:0]      load;
    logic              xfer;

    // A channel can take a word if it is empty or is being drained this cycle.
    always_comb begin
        free     = ~full | out_ready;
        in_ready = in_bcast ? (&free) : free[in_sel];
        xfer     = in_valid & in_ready;
    end

    always_comb begin
        load = '0;
        if (xfer) begin
            if (in_bcast) begin
                load = '1;
            end else begin
                load[in_sel] = 1'b1;
            end
        end
    end

    // A load wins over a drain on the same edge, so a busy channel streams at full rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= '0;
            acc_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (load[i]) begin
                    full[i] <= 1'b1;
                    data[i] <= in_data;
                end else if (out_ready[i]) begin
                    full[i] <= 1'b0;
                end
            end
            if (xfer) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = full;

    for (genvar g = 0; g < N; g++) begin : g_out
        assign out_data[g*DATA_W +: DATA_W] = data[g];
    end

endmodule

// File: tb/tb_demux_router.sv
// Randomized self-checking bench for demux_router: a per-channel reference model
// is compared every cycle, plus hand-computed checks of the key scenarios.
module tb_demux_router;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 8;
    localparam int N      = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data = '0;
    logic [2:0]        in_sel = '0;
    logic              in_bcast = 1'b0;
    logic [7:0]        out_valid;
    logic [63:0]       out_data;
    logic [7:0]        out_ready = '0;
    logic [7:0]        acc_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one slot per channel plus an accepted-word counter.
    bit         m_full [N];
    logic [7:0] m_data [N];
    int         m_cnt = 0;
    bit         model_live = 1'b0;

    demux_router #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .acc_cnt(acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        bit ok;
        if (in_bcast) begin
            ok = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (m_full[i] && !out_ready[i]) ok = 1'b0;
            end
        end else begin
            ok = !m_full[in_sel] || out_ready[in_sel];
        end
        return ok;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_full[i] = 1'b0;
                m_data[i] = 8'h00;
            end
            m_cnt = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            bit take;
            take = in_valid && model_ready();
            for (int i = 0; i < N; i++) begin
                if (take && (in_bcast || in_sel == i[2:0])) begin
                    m_full[i] = 1'b1;
                    m_data[i] = in_data;
                end else if (out_ready[i]) begin
                    m_full[i] = 1'b0;
                end
            end
            if (take) m_cnt = (m_cnt + 1) % 256;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            logic [7:0]  ev;
            logic [63:0] ed;
            for (int i = 0; i < N; i++) begin
                ev[i] = m_full[i];
                ed[i*8 +: 8] = m_data[i];
            end
            checkOutput("out_valid", {56'd0, out_valid}, {56'd0, ev});
            checkOutput("out_data", out_data, ed);
            checkOutput("acc_cnt", {56'd0, acc_cnt}, 64'(m_cnt));
            checkOutput("in_ready", {63'd0, in_ready}, {63'd0, model_ready()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input bit b, input logic [2:0] s,
                                 input logic [7:0] d, input logic [7:0] r);
        in_valid  = v;
        in_bcast  = b;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single unicast word to channel 5.
        applyStimulus(1, 0, 3'd5, 8'hA5, 8'h00);
        step();
        applyStimulus(0, 0, 3'd0, 8'h00, 8'h00);
        checkOutput("s031_valid", {56'd0, out_valid}, 64'h20);
        checkOutput("s031_slice5", {56'd0, out_data[40 +: 8]}, 64'hA5);
        checkOutput("s031_cnt", {56'd0, acc_cnt}, 64'd1);

        // Blocked on full channel 5, then accepted on channel 2.
        applyStimulus(1, 0, 3'd5, 8'h11, 8'h00);
        #1 checkOutput("s032_stall_ready", {63'd0, in_ready}, 64'd0);
        step();
        checkOutput("s032_stall_valid", {56'd0, out_valid}, 64'h20);
        checkOutput("s032_stall_data", {56'd0, out_data[40 +: 8]}, 64'hA5);
        applyStimulus(1, 0, 3'd2, 8'h22, 8'h00);
        #1 checkOutput("s032_ready", {63'd0, in_ready}, 64'd1);
        step();
        applyStimulus(0, 0, 3'd0, 8'h00, 8'h00);
        checkOutput("s032_valid", {56'd0, out_valid}, 64'h24);
        checkOutput("s032_cnt", {56'd0, acc_cnt}, 64'd2);

        // Fill channel 3, then drain and reload it on the same edge.
        applyStimulus(1, 0, 3'd3, 8'h33, 8'h00);
        step();
        applyStimulus(1, 0, 3'd3, 8'h3C, 8'h08);
        #1 checkOutput("s033_ready", {63'd0, in_ready}, 64'd1);
        step();
        applyStimulus(0, 0, 3'd0, 8'h00, 8'h00);
        checkOutput("s033_valid", {56'd0, out_valid}, 64'h2C);
        checkOutput("s033_slice3", {56'd0, out_data[24 +: 8]}, 64'h3C);
        checkOutput("s033_cnt", {56'd0, acc_cnt}, 64'd4);

        // Broadcast into empty channels, then a broadcast held off by channel 0.
        applyStimulus(0, 0, 3'd0, 8'h00, 8'hFF);
        step();
        applyStimulus(1, 1, 3'd6, 8'hFF, 8'h00);
        step();
        applyStimulus(0, 0, 3'd0, 8'h00, 8'h00);
        checkOutput("s034_valid", {56'd0, out_valid}, 64'hFF);
        checkOutput("s034_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("s034_cnt", {56'd0, acc_cnt}, 64'd5);
        applyStimulus(1, 1, 3'd1, 8'h5A, 8'hFE);
        #1 checkOutput("s034_block", {63'd0, in_ready}, 64'd0);
        step();
        checkOutput("s034_block_valid", {56'd0, out_valid}, 64'h01);
        checkOutput("s034_block_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 8'hFF;
        #1 checkOutput("s034_go", {63'd0, in_ready}, 64'd1);
        step();
        applyStimulus(0, 0, 3'd0, 8'h00, 8'h00);
        checkOutput("s034_bcast2", out_data, 64'h5A5A_5A5A_5A5A_5A5A);
        checkOutput("s034_cnt2", {56'd0, acc_cnt}, 64'd6);

        // Randomized traffic, including stalled cycles with changing inputs.
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                          3'($urandom), 8'($urandom), 8'($urandom));
            step();
        end

        // Three channels held, then reset concurrent with a valid transfer.
        applyStimulus(0, 0, 3'd0, 8'h00, 8'hFF);
        step();
        applyStimulus(1, 0, 3'd1, 8'h41, 8'h00);
        step();
        applyStimulus(1, 0, 3'd4, 8'h44, 8'h00);
        step();
        applyStimulus(1, 0, 3'd6, 8'h46, 8'h00);
        step();
        checkOutput("s036_pre", {56'd0, out_valid}, 64'h52);
        rst = 1'b1;
        applyStimulus(1, 0, 3'd0, 8'h77, 8'h00);
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 3'd0, 8'h00, 8'h00);
        checkOutput("s036_valid", {56'd0, out_valid}, 64'h00);
        checkOutput("s036_data", out_data, 64'h0);
        checkOutput("s036_cnt", {56'd0, acc_cnt}, 64'd0);

        // Walk all selects for 256 transfers so the counter wraps.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1, 0, 3'(i % 8), 8'(i % 8), 8'hFF);
            step();
            if (i == 254) checkOutput("s035_cnt255", {56'd0, acc_cnt}, 64'd255);
            if (i < 8) checkOutput("s035_slice", {56'd0, out_data[(i%8)*8 +: 8]}, 64'(i % 8));
        end
        applyStimulus(0, 0, 3'd0, 8'h00, 8'hFF);
        checkOutput("s035_wrap", {56'd0, acc_cnt}, 64'd0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_router.md
DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning the payload width in bits (minimum 1).
REQ-002 The module SHALL have parameter SEL_W, default 3, meaning the select width; the channel count is N = 2**SEL_W (default 8).
REQ-003 The module SHALL have parameter CNT_W, default 8, meaning the width of the accepted-transfer counter.
REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  reset, synchronous and active-high.
REQ-006 Port: in_valid  input  1  upstream word present.
REQ-007 Port: in_ready  output  1  the block accepts the word this cycle (combinational).
REQ-008 Port: in_data  input  DATA_W  payload.
REQ-009 Port: in_sel  input  SEL_W  destination channel index.
REQ-010 Port: in_bcast  input  1  when high, the word is delivered to all N channels and in_sel is ignored.
REQ-011 Port: out_valid  output  N  per-channel word present; bit i belongs to channel i.
REQ-012 Port: out_data  output  N*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-013 Port: out_ready  input  N  per-channel downstream accept.
REQ-014 Port: acc_cnt  output  CNT_W  count of accepted input transfers.

Function
REQ-015 Each channel i SHALL hold a one-entry register (full[i], data[i]); out_valid[i] = full[i]; out_data slice i = data[i].
REQ-016 Channel i is "free" when !full[i] or out_ready[i]; in_ready SHALL equal free[in_sel] when in_bcast=0, and the AND of free[0..N-1] when in_bcast=1.
REQ-017 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; no other input condition is a transfer.
REQ-018 On a unicast transfer, channel in_sel SHALL load in_data and set full; on a broadcast transfer, every channel SHALL load in_data and set full.
REQ-019 Latency: a word accepted at edge k SHALL appear on out_valid/out_data from edge k onward (visible one cycle after it was presented), and never combinationally.
REQ-020 An output transfer on channel i SHALL occur at an edge where full[i]=1 and out_ready[i]=1; full[i] SHALL then clear unless the same edge loads channel i.
REQ-021 Simultaneous drain and load on one channel: full[i] SHALL stay 1 and data[i] SHALL take the new word (full-rate throughput, no bubble).
REQ-022 out_ready[i] asserted while full[i]=0 SHALL have no effect.
REQ-023 Channels not targeted by a transfer SHALL hold full and data unchanged.
REQ-024 With in_valid=1 and in_ready=0, no state SHALL change; in_data/in_sel/in_bcast may change freely while stalled.
REQ-025 acc_cnt SHALL increment by 1 per input transfer (a broadcast counts once) and wrap from 2**CNT_W-1 to 0.
REQ-026 out_data of an empty channel SHALL retain its last loaded value; only out_valid qualifies it.
REQ-027 in_ready SHALL be valid even when in_valid=0 (no dependency on in_valid).

Reset
REQ-028 When rst=1 at a rising edge: all full bits SHALL clear, all data registers SHALL become 0, and acc_cnt SHALL become 0.
REQ-029 Reset SHALL take precedence over any simultaneous input or output transfer; held words are discarded.
REQ-030 During rst=1, out_valid SHALL be 0 after the first edge; in_ready SHALL follow REQ-016 from the cleared state.

Verification
REQ-031 Scenario: after reset, in_valid=1, in_sel=5, in_data=0xA5, out_ready=0x00 for one cycle -> next cycle out_valid=0x20, slice 5=0xA5, acc_cnt=1.
REQ-032 Scenario: channel 5 full, out_ready=0x00, new word to in_sel=5 -> in_ready=0, no change; word to in_sel=2 -> accepted, out_valid=0x24.
REQ-033 Scenario: channel 3 full, out_ready[3]=1, in_sel=3, in_data=0x3C -> in_ready=1; next cycle out_valid[3]=1, slice 3=0x3C (back-to-back, no bubble).
REQ-034 Scenario: all empty, in_bcast=1, in_data=0xFF -> next cycle out_valid=0xFF, all slices 0xFF, acc_cnt+1; repeat with out_ready=0xFE -> in_ready=0 until out_ready=0xFF.
REQ-035 Scenario: walk in_sel 0..7 with out_ready=0xFF and data=sel -> each channel i delivers i exactly once in order; 256 transfers total -> acc_cnt wraps to 0.
REQ-036 Scenario: three channels full, rst=1 for one cycle concurrent with a valid transfer -> out_valid=0x00, all slices 0, acc_cnt=0, the concurrent word is lost.
